// File: rtl/serial_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a small first-word fall-through FIFO.
// Define SERIAL_RX_MAJORITY_EN to decide each bit by 2-of-3 majority at ticks 7/8/9.
module serial_rx_fifo #(
    parameter int unsigned DIVISOR = 163,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rxd_in,
    input  logic       read_in,
    input  logic       clear_in,
    output logic [7:0] data_out,
    output logic       avail_out,
    output logic       full_out,
    output logic       overrun_out,
    output logic       frame_err_out,
    output logic       irq_out
);

    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0] PRESC_MAX = 16'(DIVISOR - 1);
`ifdef SERIAL_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_TICK = 4'd9;
`else
    localparam logic [3:0] DECIDE_TICK = 4'd7;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic               rxq, rxs;
    logic [15:0]        presc;
    logic [3:0]         tick_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               tick, decide, bit_val;
    logic               empty, full, pop, push, stop_good, stop_bad;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rxq <= 1'b1;
            rxs <= 1'b1;
        end else begin
            rxq <= rxd_in;
            rxs <= rxq;
        end
    end

    assign tick   = (presc == PRESC_MAX);
    assign decide = tick && (tick_cnt == DECIDE_TICK) && (state != IDLE);

`ifdef SERIAL_RX_MAJORITY_EN
    logic s7, s8;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == 4'd7) s7 <= rxs;
            if (tick_cnt == 4'd8) s8 <= rxs;
        end
    end
    assign bit_val = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`else
    assign bit_val = rxs;
`endif

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop       = read_in && !empty;
    assign stop_good = (state == STOP) && decide && bit_val;
    assign stop_bad  = (state == STOP) && decide && !bit_val;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = stop_good && (!full || pop);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            presc         <= '0;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            overrun_out   <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            if (state == IDLE && !rxs) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + 16'd1;
                if (tick) tick_cnt <= tick_cnt + 4'd1;
            end

            case (state)
                IDLE:  if (!rxs) state <= START;
                START: if (decide) begin
                    state   <= bit_val ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA:  if (decide) begin
                    shreg   <= {bit_val, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP:  if (decide) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A new error in the same cycle as clear_in keeps the flag set.
            if (stop_good && full && !pop) overrun_out <= 1'b1;
            else if (clear_in)             overrun_out <= 1'b0;
            if (stop_bad)                  frame_err_out <= 1'b1;
            else if (clear_in)             frame_err_out <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end

    assign data_out  = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
    assign avail_out = !empty;
    assign full_out  = full;
    assign irq_out   = avail_out | overrun_out | frame_err_out;

endmodule
